lfsr_ks_sched: RTL

Keystream scheduler for the 16-bit filtered-LFSR generator. It seeds the generator, runs a fixed warm-up that discards output, then shares the keystream between two requesters. Each grant packs eight filter-output bits into one byte. It sits between the generator instance and the two keystream consumers, and is the only block that drives the generator's load and step controls.

---
 rtl/lfsr_ks_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/lfsr_ks_sched.sv
// lfsr_ks_sched: keystream scheduler for the 16-bit filtered-LFSR generator.
// Seeds the generator, discards WARMUP steps, then serves 8-bit keystream
// bytes to two requesters by round-robin.
//
// Parameters:
//   WARMUP     generator steps discarded after every seed load (0..1023)
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start/seed seed-load request and value (honoured in IDLE and ARB)
//   ready      keystream service available (ARB, GEN, ACK)
//   busy       seeding in progress (LOAD, WARM)
//   req        per-requester byte request, level-sensitive
//   gnt        one-hot grant, held through GEN and ACK
//   ack        one-hot single-cycle byte-delivered strobe
//   data       last delivered byte, MSB = first keystream bit
//   lfsr_load, lfsr_seed, lfsr_step   generator controls
//   ks_bit     generator filter output for its current state
//   seed_fix   sticky: a zero seed was replaced
// Build option:
//   LFSR_KS_ZERO_SEED_GUARD_EN  replace a zero seed by 16'hACE1 and set seed_fix
module lfsr_ks_sched #(
  parameter int unsigned WARMUP = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        ready,
  output logic        busy,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [7:0]  data,
  output logic        lfsr_load,
  output logic [15:0] lfsr_seed,
  output logic        lfsr_step,
  input  logic        ks_bit,
  output logic        seed_fix
);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, ARB, GEN, ACK} state_t;

  localparam logic [9:0] WARM_INIT = 10'(WARMUP);

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  warm_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_q;
  logic        ptr;
  logic [1:0]  gnt_q;
  logic [1:0]  gnt_pick;
  logic        seed_take;
  logic [15:0] seed_eff;

`ifdef LFSR_KS_ZERO_SEED_GUARD_EN
  logic seed_fix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_fix_q <= 1'b0;
    end else if (seed_take && (seed == '0)) begin
      seed_fix_q <= 1'b1;
    end
  end

  assign seed_fix = seed_fix_q;
  assign seed_eff = (seed == '0) ? 16'hACE1 : seed;
`else
  assign seed_fix = 1'b0;
  assign seed_eff = seed;
`endif

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    gnt_pick = req;
    if (req == 2'b11) begin
      gnt_pick = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    seed_take = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          seed_take = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        busy      = 1'b1;
        state_nxt = (WARMUP == 0) ? ARB : WARM;
      end
      WARM: begin
        lfsr_step = 1'b1;
        busy      = 1'b1;
        if (warm_cnt <= 10'd1) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        ready = 1'b1;
        // A reseed request takes precedence over any pending byte request.
        if (start) begin
          seed_take = 1'b1;
          state_nxt = LOAD;
        end else if (req != '0) begin
          state_nxt = GEN;
        end
      end
      GEN: begin
        ready     = 1'b1;
        lfsr_step = 1'b1;
        if (bit_cnt == 3'd7) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        ready     = 1'b1;
        state_nxt = ARB;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_seed <= '0;
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      data      <= '0;
      gnt_q     <= '0;
      ptr       <= 1'b0;
    end else begin
      if (seed_take) begin
        lfsr_seed <= seed_eff;
      end
      if (state == LOAD) begin
        warm_cnt <= WARM_INIT;
      end else if ((state == WARM) && (warm_cnt != '0)) begin
        warm_cnt <= warm_cnt - 10'd1;
      end
      if ((state == ARB) && (state_nxt == GEN)) begin
        gnt_q   <= gnt_pick;
        bit_cnt <= '0;
      end
      if (state == GEN) begin
        shift_q <= {shift_q[5:0], ks_bit};
        bit_cnt <= bit_cnt + 3'd1;
        // The eighth bit goes straight into data so the byte is visible
        // in the ACK cycle together with the strobe.
        if (bit_cnt == 3'd7) begin
          data <= {shift_q, ks_bit};
        end
      end
      if (state == ACK) begin
        gnt_q <= '0;
        ptr   <= ~ptr;
      end
    end
  end

  assign gnt = gnt_q;
  assign ack = (state == ACK) ? gnt_q : 2'b00;

endmodule
